// File: rtl/softusb_txpkt.sv
// USB packet transmit sequencer: PID, payload, optional CRC16, then EOP via the PHY.
// Optional keep-alive EOP request path is built when SOFTUSB_TXPKT_EOP_EN is defined.
//
// Handshakes:
//  - PHY side: tx_data is held while tx_valid=1; a byte is taken on an edge where
//    tx_valid & tx_ready, and the next byte appears on tx_data right after that edge.
//  - Payload side: in_ready is a one-cycle registered pop strobe raised the cycle
//    after in_data was captured; the source drops that byte when in_valid & in_ready.
module softusb_txpkt #(
  parameter int LEN_W = 10
) (
  input  logic             usb_clk,
  input  logic             usb_rst,
  input  logic             start,
  input  logic [3:0]       pid,
  input  logic [LEN_W-1:0] len,
  input  logic             crc_en,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic             tx_busy,
  output logic             busy,
  output logic             done,
  output logic             underrun,
`ifdef SOFTUSB_TXPKT_EOP_EN
  input  logic             eop_req,
  output logic             generate_eop,
`endif
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PID      = 3'd1,
    S_DATA     = 3'd2,
    S_CRC_LO   = 3'd3,
    S_CRC_HI   = 3'd4,
    S_WAIT     = 3'd5,
    S_ABORT    = 3'd6,
    S_EOP_RISE = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             underrun_q, underrun_d;
  logic [15:0]      crc_q, crc_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             crc_en_q, crc_en_d;
  logic             ack;
`ifdef SOFTUSB_TXPKT_EOP_EN
  logic             gen_eop_q, gen_eop_d;
`endif

  // USB CRC16, reflected form: data enters LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign ack = tx_valid_q & tx_ready;

  always_ff @(posedge usb_clk) begin
    if (usb_rst) begin
      state_q    <= S_IDLE;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      crc_q      <= 16'hFFFF;
      count_q    <= '0;
      crc_en_q   <= 1'b0;
`ifdef SOFTUSB_TXPKT_EOP_EN
      gen_eop_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      crc_q      <= crc_d;
      count_q    <= count_d;
      crc_en_q   <= crc_en_d;
`ifdef SOFTUSB_TXPKT_EOP_EN
      gen_eop_q  <= gen_eop_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    in_ready_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    crc_d      = crc_q;
    count_d    = count_q;
    crc_en_d   = crc_en_q;
`ifdef SOFTUSB_TXPKT_EOP_EN
    gen_eop_d  = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          crc_en_d   = crc_en;
          count_d    = len;
          crc_d      = 16'hFFFF;
          tx_data_d  = {~pid, pid};
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = S_PID;
        end
`ifdef SOFTUSB_TXPKT_EOP_EN
        else if (eop_req) begin
          gen_eop_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_EOP_RISE;
        end
`endif
      end
      S_PID, S_DATA: begin
        if (ack) begin
          if (count_q != '0) begin
            // A payload byte must be ready exactly when the PHY wants the next one.
            if (in_valid) begin
              in_ready_d = 1'b1;
              tx_data_d  = in_data;
              crc_d      = crc16_byte(crc_q, in_data);
              count_d    = count_q - LEN_W'(1);
              state_d    = S_DATA;
            end else begin
              tx_valid_d = 1'b0;
              underrun_d = 1'b1;
              state_d    = S_ABORT;
            end
          end else if (crc_en_q) begin
            tx_data_d = ~crc_q[7:0];
            state_d   = S_CRC_LO;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = S_WAIT;
          end
        end
      end
      S_CRC_LO: begin
        if (ack) begin
          tx_data_d = ~crc_q[15:8];
          state_d   = S_CRC_HI;
        end
      end
      S_CRC_HI: begin
        if (ack) begin
          tx_valid_d = 1'b0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!tx_busy) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_ABORT: begin
        if (!tx_busy) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_EOP_RISE: begin
        // Keep-alive: the PHY must first show it started the EOP before WAIT sees idle.
        if (tx_busy) state_d = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign underrun  = underrun_q;
  assign state_dbg = state_q;
`ifdef SOFTUSB_TXPKT_EOP_EN
  assign generate_eop = gen_eop_q;
`endif

endmodule
